// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// instq_entry_t is the per-slot payload. The order and widths of its fields
// are the layout seen by decode_stage.
package inst_queue_pkg;

    localparam int INSTQ_XLEN      = 32;
    localparam int INSTQ_EXCCODE_W = 5;

    typedef struct packed {
        logic [INSTQ_XLEN-1:0]      pc;
        logic [INSTQ_XLEN-1:0]      inst;
        logic                       exc;
        logic [INSTQ_EXCCODE_W-1:0] exccode;
    } instq_entry_t;

endpackage

// File: rtl/instq_slot_ram.sv
// DEPTH-entry slot store for inst_queue: one allocation write port, one fill port, ISSUE_W reads.
// Latency: writes land on the next posedge; reads at head+i are combinational.
// Backpressure: none here; inst_queue only issues writes that are legal.
//
// Ports: clk/reset; clear drops every filled bit (flush); alloc_* writes a whole
// entry at alloc_idx with filled=alloc_exc and inst=0; fill_* writes inst at
// fill_idx and sets its filled bit; head selects the read window; filled exposes
// the per-slot filled bits; rd_entry[i] is the entry at head+i.
module instq_slot_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       alloc_en,
    input  logic [PW-1:0]              alloc_idx,
    input  logic [INSTQ_XLEN-1:0]      alloc_pc,
    input  logic                       alloc_exc,
    input  logic [INSTQ_EXCCODE_W-1:0] alloc_exccode,
    input  logic                       fill_en,
    input  logic [PW-1:0]              fill_idx,
    input  logic [INSTQ_XLEN-1:0]      fill_inst,
    input  logic [PW-1:0]              head,
    output logic [DEPTH-1:0]           filled,
    output instq_entry_t               rd_entry [ISSUE_W]
);

    instq_entry_t slots [DEPTH];

    // Alloc and fill never target the same slot: alloc writes at tail (not
    // live), fill targets a live unfilled slot.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            filled <= '0;
        end else begin
            if (alloc_en) filled[alloc_idx] <= alloc_exc;
            if (fill_en)  filled[fill_idx]  <= 1'b1;
        end
    end

    // Payload carries no reset; filled/count gate all visibility.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            slots[alloc_idx].pc      <= alloc_pc;
            slots[alloc_idx].inst    <= '0;
            slots[alloc_idx].exc     <= alloc_exc;
            slots[alloc_idx].exccode <= alloc_exccode;
        end
        if (fill_en) begin
            slots[fill_idx].inst <= fill_inst;
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_entry[i] = slots[head + PW'(i)];
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: allocate at fetch request, fill in order, dequeue ISSUE_W-wide.
// Latency: response or exception entry visible on out_valid the cycle after it arrives (no bypass).
// Backpressure: req_ready drops when full or when DEPTH bus responses are already outstanding.
//
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_pc/req_exc/req_exccode
// allocate; inst_data_ok/inst_rdata deliver in-order responses; flush discards all
// entries; out_valid (thermometer), out_pc/out_inst/out_exc/out_exccode (slot i at
// head+i); out_pop entries consumed; count occupancy.
// Optional: define INST_QUEUE_PERFCNT_EN to add perfcnt_empty_stall,
// perfcnt_full_stall and perfcnt_dropped.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [INSTQ_XLEN-1:0]            req_pc,
    input  logic                             req_exc,
    input  logic [INSTQ_EXCCODE_W-1:0]       req_exccode,
    input  logic                             inst_data_ok,
    input  logic [INSTQ_XLEN-1:0]            inst_rdata,
    input  logic                             flush,
    output logic [ISSUE_W-1:0]               out_valid,
    output logic [INSTQ_XLEN*ISSUE_W-1:0]    out_pc,
    output logic [INSTQ_XLEN*ISSUE_W-1:0]    out_inst,
    output logic [ISSUE_W-1:0]               out_exc,
    output logic [INSTQ_EXCCODE_W*ISSUE_W-1:0] out_exccode,
    input  logic [$clog2(ISSUE_W+1)-1:0]     out_pop,
    output logic [$clog2(DEPTH+1)-1:0]       count
`ifdef INST_QUEUE_PERFCNT_EN
    ,
    output logic [31:0]                      perfcnt_empty_stall,
    output logic [31:0]                      perfcnt_full_stall,
    output logic [31:0]                      perfcnt_dropped
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(ISSUE_W+1);

    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    discard;      // responses still owed to flushed requests
    logic [DEPTH-1:0] filled;
    instq_entry_t     rd_entry [ISSUE_W];

    logic [CW:0]      unfilled;     // one extra bit so unfilled+discard cannot wrap
    logic             fill_hit;
    logic [PW-1:0]    fill_idx;
    logic [OW-1:0]    lead;
    logic [OW-1:0]    pop_eff;
    logic             alloc;
    logic             drop;
    logic             fill_en;
    logic [CW:0]      disc_sum;
    logic [CW-1:0]    disc_flush;

    // Outstanding-response bookkeeping: count unfilled live entries and find
    // the oldest one, which is where the next response belongs.
    always_comb begin
        unfilled = '0;
        fill_hit = 1'b0;
        fill_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && !filled[head + PW'(i)]) begin
                unfilled = unfilled + 1'b1;
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = head + PW'(i);
                end
            end
        end
    end

    // out_valid is a thermometer: stop at the first missing or unfilled slot.
    always_comb begin
        logic run;
        run  = 1'b1;
        lead = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            run = run && (CW'(i) < count_q) && filled[head + PW'(i)];
            out_valid[i] = run;
            if (run) lead = lead + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            out_pc[INSTQ_XLEN*i +: INSTQ_XLEN]                = rd_entry[i].pc;
            out_inst[INSTQ_XLEN*i +: INSTQ_XLEN]              = rd_entry[i].inst;
            out_exc[i]                                        = rd_entry[i].exc;
            out_exccode[INSTQ_EXCCODE_W*i +: INSTQ_EXCCODE_W] = rd_entry[i].exccode;
        end
    end

    // Ready is judged on the pre-pop count, so a full queue never allocates.
    assign req_ready = !reset && !flush && (count_q < CW'(DEPTH))
                       && ((unfilled + {1'b0, discard}) < (CW+1)'(DEPTH));
    assign alloc   = req_valid && req_ready;
    assign pop_eff = flush ? '0 : ((out_pop > lead) ? lead : out_pop);
    assign drop    = inst_data_ok && (discard != '0);
    assign fill_en = inst_data_ok && (discard == '0) && fill_hit && !flush && !reset;
    assign count   = count_q;

    // On flush every unfilled entry becomes a stale response; a response in
    // the flush cycle itself already pays off one of those (or an older one).
    always_comb begin
        disc_sum = {1'b0, discard} + unfilled;
        if (inst_data_ok && disc_sum != '0) disc_sum = disc_sum - 1'b1;
        if (disc_sum > (CW+1)'(DEPTH)) disc_sum = (CW+1)'(DEPTH);
        disc_flush = disc_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            discard <= '0;
        end else if (flush) begin
            head    <= tail;
            count_q <= '0;
            discard <= disc_flush;
        end else begin
            head    <= head + PW'(pop_eff);
            tail    <= tail + PW'(alloc);
            count_q <= count_q + CW'(alloc) - CW'(pop_eff);
            if (drop) discard <= discard - 1'b1;
        end
    end

    instq_slot_ram #(
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W)
    ) u_slot_ram (
        .clk           (clk),
        .reset         (reset),
        .clear         (flush),
        .alloc_en      (alloc),
        .alloc_idx     (tail),
        .alloc_pc      (req_pc),
        .alloc_exc     (req_exc),
        .alloc_exccode (req_exccode),
        .fill_en       (fill_en),
        .fill_idx      (fill_idx),
        .fill_inst     (inst_rdata),
        .head          (head),
        .filled        (filled),
        .rd_entry      (rd_entry)
    );

    a_pop_within_valid: assert property (@(posedge clk) disable iff (reset || flush)
        !(out_pop > lead));
    a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
        !(inst_data_ok && discard == '0 && unfilled == '0));

`ifdef INST_QUEUE_PERFCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perfcnt_empty_stall <= '0;
            perfcnt_full_stall  <= '0;
            perfcnt_dropped     <= '0;
        end else begin
            if (count_q == '0 && !flush)               perfcnt_empty_stall <= perfcnt_empty_stall + 1'b1;
            if (req_valid && count_q == CW'(DEPTH))    perfcnt_full_stall  <= perfcnt_full_stall + 1'b1;
            if (inst_data_ok && (discard != '0 || flush)) perfcnt_dropped  <= perfcnt_dropped + 1'b1;
        end
    end
`endif

endmodule
